// File: rtl/axi_mock_cu_bank.sv
// axi_mock_cu_bank: AXI4-Lite slave exposing one mock compute-unit register set per device.
// Each set holds a CONTROL word (busy / read count / write count), a STATUS byte,
// a sticky command-seen EVENT register with a saturating command counter, and an IRQ enable.
module axi_mock_cu_bank #(
   parameter int NUM_DEVICES = 2,
   parameter int ADDR_WIDTH  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     s_axi_arvalid,
   output logic                     s_axi_arready,
   input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
   output logic                     s_axi_rvalid,
   input  logic                     s_axi_rready,
   output logic [31:0]              s_axi_rdata,
   output logic [1:0]               s_axi_rresp,
   input  logic                     s_axi_awvalid,
   output logic                     s_axi_awready,
   input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
   input  logic                     s_axi_wvalid,
   output logic                     s_axi_wready,
   input  logic [31:0]              s_axi_wdata,
   input  logic [3:0]               s_axi_wstrb,
   output logic                     s_axi_bvalid,
   input  logic                     s_axi_bready,
   output logic [1:0]               s_axi_bresp,
   output logic [NUM_DEVICES-1:0]   mock_busy,
   output logic [8*NUM_DEVICES-1:0] mock_read_count,
   output logic [8*NUM_DEVICES-1:0] mock_write_count,
   output logic [8*NUM_DEVICES-1:0] mock_status,
   input  logic [NUM_DEVICES-1:0]   cu_command_seen,
   output logic                     irq
);

   localparam int DEV_W = ADDR_WIDTH - 4;
   // One extra bit so NUM_DEVICES itself is representable even when it fills the device field.
   localparam logic [DEV_W:0] NUM_DEV_EXT = (DEV_W+1)'(NUM_DEVICES);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Read channel state
   logic        arready_q, arready_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;

   // Write channel state; captured address drops the ignored byte-offset bits
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  aw_held_q, aw_held_d;
   logic                  w_held_q, w_held_d;
   logic [ADDR_WIDTH-3:0] aw_addr_q, aw_addr_d;
   logic [31:0]           w_data_q, w_data_d;
   logic [3:0]            w_strb_q, w_strb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  irq_q, irq_d;

   logic                  ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic                  ar_ok, wr_ok, wr_fire;
   logic [DEV_W-1:0]      ar_dev, wr_dev;
   logic [1:0]            ar_off, wr_off;
   logic [ADDR_WIDTH-3:0] wr_addr;
   logic [31:0]           wr_data;
   logic [3:0]            wr_strb;
   logic [31:0]           rd_word;
   logic [128*NUM_DEVICES-1:0] reg_rd_flat;
   logic [NUM_DEVICES-1:0]     irq_src;
   logic                  unused_bits;

   assign ar_hs = s_axi_arvalid & arready_q;
   assign r_hs  = rvalid_q & s_axi_rready;
   assign aw_hs = s_axi_awvalid & awready_q;
   assign w_hs  = s_axi_wvalid & wready_q;
   assign b_hs  = bvalid_q & s_axi_bready;

   assign ar_dev = s_axi_araddr[ADDR_WIDTH-1:4];
   assign ar_off = s_axi_araddr[3:2];
   assign ar_ok  = {1'b0, ar_dev} < NUM_DEV_EXT;

   // A channel accepted this very cycle counts as held, so the update fires on the
   // same edge that completes the pair.
   assign wr_addr = aw_held_q ? aw_addr_q : s_axi_awaddr[ADDR_WIDTH-1:2];
   assign wr_data = w_held_q ? w_data_q : s_axi_wdata;
   assign wr_strb = w_held_q ? w_strb_q : s_axi_wstrb;
   assign wr_dev  = wr_addr[ADDR_WIDTH-3:2];
   assign wr_off  = wr_addr[1:0];
   assign wr_ok   = {1'b0, wr_dev} < NUM_DEV_EXT;
   assign wr_fire = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;

   assign unused_bits = &{1'b0, s_axi_araddr[1:0], s_axi_awaddr[1:0], wr_data};

   // Read mux over the current (pre-write) register contents
   always_comb begin
      rd_word = '0;
      for (int d = 0; d < NUM_DEVICES; d++) begin
         if (ar_dev == DEV_W'(d)) begin
            rd_word = reg_rd_flat[128*d + 32*int'(ar_off) +: 32];
         end
      end
   end

   // AXI handshake bookkeeping and response generation
   always_comb begin
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      aw_addr_d = aw_addr_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      irq_d     = |irq_src;

      if (ar_hs) begin
         arready_d = 1'b0;
         rvalid_d  = 1'b1;
         rdata_d   = ar_ok ? rd_word : 32'h0;
         rresp_d   = ar_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_hs) begin
         arready_d = 1'b1;
         rvalid_d  = 1'b0;
      end

      if (aw_hs) begin
         awready_d = 1'b0;
         aw_held_d = 1'b1;
         aw_addr_d = s_axi_awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
         wready_d = 1'b0;
         w_held_d = 1'b1;
         w_data_d = s_axi_wdata;
         w_strb_d = s_axi_wstrb;
      end

      if (wr_fire) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
         bvalid_d  = 1'b0;
         awready_d = 1'b1;
         wready_d  = 1'b1;
      end
   end

   // Channel registers; reset drops any half-captured write and pending responses
   always_ff @(posedge clk) begin
      if (reset) begin
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         awready_q <= 1'b1;
         wready_q  <= 1'b1;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         aw_addr_q <= aw_addr_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         irq_q     <= irq_d;
      end
   end

   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign irq           = irq_q;

   generate
      for (genvar gi = 0; gi < NUM_DEVICES; gi++) begin : g_dev
         logic       busy_q, busy_d;
         logic       irq_en_q, irq_en_d;
         logic       sticky_q, sticky_d;
         logic [7:0] rd_cnt_q, rd_cnt_d;
         logic [7:0] wr_cnt_q, wr_cnt_d;
         logic [7:0] status_q, status_d;
         logic [7:0] cmd_cnt_q, cmd_cnt_d;
         logic [7:0] cnt_base;
         logic       sel, clr_sticky, clr_count;

         assign sel = wr_fire & wr_ok & (wr_dev == DEV_W'(gi));

         // Byte-lane register writes, then EVENT clears overridden by a same-cycle command pulse
         always_comb begin
            busy_d     = busy_q;
            rd_cnt_d   = rd_cnt_q;
            wr_cnt_d   = wr_cnt_q;
            status_d   = status_q;
            irq_en_d   = irq_en_q;
            clr_sticky = 1'b0;
            clr_count  = 1'b0;
            if (sel) begin
               case (wr_off)
                  2'd0: begin
                     if (wr_strb[0]) busy_d   = wr_data[1];
                     if (wr_strb[1]) rd_cnt_d = wr_data[15:8];
                     if (wr_strb[2]) wr_cnt_d = wr_data[23:16];
                  end
                  2'd1: if (wr_strb[0]) status_d = wr_data[7:0];
                  2'd2: begin
                     clr_sticky = wr_strb[0] & wr_data[0];
                     clr_count  = wr_strb[3] & wr_data[31];
                  end
                  default: if (wr_strb[0]) irq_en_d = wr_data[0];
               endcase
            end
            cnt_base  = clr_count ? 8'h00 : cmd_cnt_q;
            cmd_cnt_d = cnt_base;
            sticky_d  = clr_sticky ? 1'b0 : sticky_q;
            if (cu_command_seen[gi]) begin
               sticky_d = 1'b1;
               if (cnt_base != 8'hFF) cmd_cnt_d = cnt_base + 8'd1;
            end
         end

         // Per-device register file
         always_ff @(posedge clk) begin
            if (reset) begin
               busy_q    <= 1'b0;
               rd_cnt_q  <= '0;
               wr_cnt_q  <= '0;
               status_q  <= '0;
               irq_en_q  <= 1'b0;
               sticky_q  <= 1'b0;
               cmd_cnt_q <= '0;
            end else begin
               busy_q    <= busy_d;
               rd_cnt_q  <= rd_cnt_d;
               wr_cnt_q  <= wr_cnt_d;
               status_q  <= status_d;
               irq_en_q  <= irq_en_d;
               sticky_q  <= sticky_d;
               cmd_cnt_q <= cmd_cnt_d;
            end
         end

         assign reg_rd_flat[128*gi      +: 32] = {8'h00, wr_cnt_q, rd_cnt_q, 6'b0, busy_q, 1'b0};
         assign reg_rd_flat[128*gi + 32 +: 32] = {24'h0, status_q};
         assign reg_rd_flat[128*gi + 64 +: 32] = {16'h0, cmd_cnt_q, 7'h0, sticky_q};
         assign reg_rd_flat[128*gi + 96 +: 32] = {31'h0, irq_en_q};

         assign mock_busy[gi]              = busy_q;
         assign mock_read_count[8*gi +: 8]  = rd_cnt_q;
         assign mock_write_count[8*gi +: 8] = wr_cnt_q;
         assign mock_status[8*gi +: 8]      = status_q;
         assign irq_src[gi]                 = sticky_q & irq_en_q;
      end
   endgenerate

endmodule
